// File: rtl/bsmodadd_if.sv
// bsmodadd_if: serial operand/result bus with single-pulse frame sync
interface bsmodadd_if;
    logic a;
    logic b;
    logic isync;
    logic q;
    logic osync;
    modport master(output a, output b, output isync, input q, input osync);
    modport slave(input a, input b, input isync, output q, output osync);
endinterface

// File: rtl/bsmodadd.sv
// bsmodadd: bit-serial (a + b) mod MOD, LSB-first, one frame every LEN cycles
module bsmodadd #(
    parameter int LEN = 94,
    parameter int MOD = 29
) (
    input logic clk,
    input logic reset,
    bsmodadd_if.slave bus
);
    localparam int CW = $clog2(LEN);
    localparam logic [LEN-1:0] M = LEN'(MOD);
    typedef enum logic {CIDLE, CAP} cstate_t;
    typedef enum logic {OIDLE, OUT} ostate_t;
    cstate_t cstate;
    ostate_t ostate;
    logic [CW-1:0] ci, co, idx;
    logic c, w, cin, win, s, d, c_nx, w_nx, active, last, sel;
    logic [LEN-1:0] sreg, dreg, s_nx, d_nx, obuf, chosen;
    // One bit of the running sum and of sum-minus-modulus; isync forces a fresh start
    always_comb begin
        active = bus.isync | (cstate == CAP);
        idx = bus.isync ? '0 : ci;
        cin = ~bus.isync & c;
        win = ~bus.isync & w;
        s = bus.a ^ bus.b ^ cin;
        c_nx = (bus.a & bus.b) | (cin & (bus.a ^ bus.b));
        d = s ^ M[idx] ^ win;
        w_nx = (~s & (M[idx] | win)) | (M[idx] & win);
        s_nx = {s, sreg[LEN-1:1]};
        d_nx = {d, dreg[LEN-1:1]};
        last = active & (idx == CW'(LEN - 1));
        sel = c_nx | ~w_nx;
        chosen = sel ? d_nx : s_nx;
    end
    // Capture engine: accumulate both candidate results while a frame is arriving
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cstate <= CIDLE;
            ci <= '0;
            c <= 1'b0;
            w <= 1'b0;
            sreg <= '0;
            dreg <= '0;
        end else if (active) begin
            c <= c_nx;
            w <= w_nx;
            sreg <= s_nx;
            dreg <= d_nx;
            ci <= last ? '0 : idx + 1'b1;
            cstate <= last ? CIDLE : CAP;
        end
    end
    // Output engine: a completed frame loads the buffer and is streamed out LSB-first
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ostate <= OIDLE;
            co <= '0;
            obuf <= '0;
            bus.q <= 1'b0;
            bus.osync <= 1'b0;
        end else if (last) begin
            ostate <= OUT;
            co <= '0;
            obuf <= chosen >> 1;
            bus.q <= chosen[0];
            bus.osync <= 1'b1;
        end else if (ostate == OUT && co != CW'(LEN - 1)) begin
            co <= co + 1'b1;
            obuf <= obuf >> 1;
            bus.q <= obuf[0];
            bus.osync <= 1'b0;
        end else begin
            ostate <= OIDLE;
            co <= '0;
            bus.q <= 1'b0;
            bus.osync <= 1'b0;
        end
    end
endmodule

// File: tb/tb_bsmodadd.sv
// tb_bsmodadd: random and directed frames against a frame-level arithmetic model
module tb_bsmodadd;
    localparam int LEN = 8;
    localparam int NC = 1024;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a_d = 1'b0, b_d = 1'b0, is_d = 1'b0;
    int cyc = 0, checks = 0, errors = 0;
    logic exp_q[2][NC];
    logic exp_o[2][NC];
    logic qv[2], ov[2];
    logic gath[2];
    int gi[2], ocyc[2], os_last[2], gap8[2], res_val[2], res_cyc[2], res_cnt[2];
    logic [LEN-1:0] gv[2];
    logic coll = 1'b0;
    int mi = 0;
    logic [LEN-1:0] ma, mb;

    bsmodadd_if if0();
    bsmodadd_if if1();
    assign if0.a = a_d;
    assign if0.b = b_d;
    assign if0.isync = is_d;
    assign if1.a = a_d;
    assign if1.b = b_d;
    assign if1.isync = is_d;
    assign qv[0] = if0.q;
    assign ov[0] = if0.osync;
    assign qv[1] = if1.q;
    assign ov[1] = if1.osync;

    bsmodadd #(.LEN(LEN), .MOD(29)) dut0(.clk(clk), .reset(rst), .bus(if0));
    bsmodadd #(.LEN(LEN), .MOD(251)) dut1(.clk(clk), .reset(rst), .bus(if1));

    always #5 clk = ~clk;

    function automatic int mod_of(int d);
        return d == 1 ? 251 : 29;
    endfunction

    function automatic logic [LEN-1:0] expect_sum(int x, int y, int m);
        int s;
        s = x + y;
        return LEN'(s >= m ? s - m : s);
    endfunction

    task automatic chk(string nm, int d, logic [31:0] got, logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", nm, d, cyc, got, expv);
        end
    endtask

    // Reference model: collect LEN operand bits per frame, schedule the result LEN cycles after isync
    always @(posedge clk) begin
        if (rst) coll = 1'b0;
        else begin
            if (is_d) begin
                coll = 1'b1;
                mi = 0;
            end
            if (coll) begin
                ma[mi] = a_d;
                mb[mi] = b_d;
                mi++;
                if (mi == LEN) begin
                    coll = 1'b0;
                    for (int d = 0; d < 2; d++) begin
                        logic [LEN-1:0] r;
                        r = expect_sum(int'(ma), int'(mb), mod_of(d));
                        if (cyc + LEN < NC) begin
                            for (int i = 0; i < LEN; i++) exp_q[d][cyc+1+i] = r[i];
                            exp_o[d][cyc+1] = 1'b1;
                        end
                    end
                end
            end
        end
        cyc++;
    end

    // Cycle-by-cycle compare of both DUTs against the model
    always @(negedge clk)
        if (cyc < NC)
            for (int d = 0; d < 2; d++) begin
                chk("q", d, 32'(qv[d]), 32'(exp_q[d][cyc]));
                chk("osync", d, 32'(ov[d]), 32'(exp_o[d][cyc]));
            end

    // Result monitor: reassemble each output frame for the literal checks
    always @(negedge clk)
        for (int d = 0; d < 2; d++)
            if (rst) gath[d] = 1'b0;
            else begin
                if (ov[d]) begin
                    if (cyc - os_last[d] == LEN) gap8[d]++;
                    os_last[d] = cyc;
                    gath[d] = 1'b1;
                    gi[d] = 0;
                    ocyc[d] = cyc;
                end
                if (gath[d]) begin
                    gv[d][gi[d]] = qv[d];
                    gi[d]++;
                    if (gi[d] == LEN) begin
                        gath[d] = 1'b0;
                        res_val[d] = int'(gv[d]);
                        res_cyc[d] = ocyc[d];
                        res_cnt[d]++;
                    end
                end
            end

    task automatic go(int k);
        while (cyc < k) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send(int x, int y, int k, int n);
        logic [LEN-1:0] xa, yb;
        xa = LEN'(x);
        yb = LEN'(y);
        go(k);
        for (int i = 0; i < n; i++) begin
            is_d = (i == 0);
            a_d = xa[i];
            b_d = yb[i];
            @(posedge clk);
            #2;
        end
        is_d = 1'b0;
        a_d = 1'b0;
        b_d = 1'b0;
    endtask

    task automatic do_reset(int k);
        go(k);
        rst = 1'b1;
        for (int d = 0; d < 2; d++)
            for (int i = cyc; i < NC; i++) begin
                exp_q[d][i] = 1'b0;
                exp_o[d][i] = 1'b0;
            end
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_q", d, 32'(qv[d]), 32'd0);
            chk("rst_osync", d, 32'(ov[d]), 32'd0);
        end
        go(k + 2);
        rst = 1'b0;
    endtask

    initial begin
        int n0, g0, t;
        int da[4], db[4], dr[4];
        da = '{20, 28, 0, 14};
        db = '{15, 28, 0, 15};
        dr = '{6, 27, 0, 0};
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NC; i++) begin
                exp_q[d][i] = 1'b0;
                exp_o[d][i] = 1'b0;
            end
            gath[d] = 1'b0;
            gi[d] = 0;
            ocyc[d] = 0;
            os_last[d] = -100;
            gap8[d] = 0;
            res_val[d] = 0;
            res_cyc[d] = 0;
            res_cnt[d] = 0;
            gv[d] = '0;
        end
        go(1);
        for (int d = 0; d < 2; d++) begin
            chk("reset_q", d, 32'(qv[d]), 32'd0);
            chk("reset_osync", d, 32'(ov[d]), 32'd0);
        end
        go(3);
        rst = 1'b0;
        send(5, 7, 10, LEN);
        go(30);
        chk("first_cycle", 0, res_cyc[0], 18);
        chk("first_value", 0, res_val[0], 12);
        chk("first_count", 0, res_cnt[0], 1);
        t = 40;
        for (int i = 0; i < 4; i++) begin
            send(da[i], db[i], t, LEN);
            go(t + 20);
            chk("directed", 0, res_val[0], dr[i]);
            t += 20;
        end
        send(250, 250, t, LEN);
        go(t + 20);
        chk("overflow251", 1, res_val[1], 249);
        t += 20;
        n0 = res_cnt[0];
        g0 = gap8[0];
        for (int k = 0; k < 20; k++) send(int'($urandom_range(28)), int'($urandom_range(28)), t + LEN * k, LEN);
        go(t + LEN * 20 + 20);
        chk("b2b_count", 0, res_cnt[0] - n0, 20);
        chk("b2b_spacing", 0, gap8[0] - g0, 19);
        t = 330;
        n0 = res_cnt[0];
        send(9, 3, t, 3);
        send(11, 13, t + 3, LEN);
        go(t + 30);
        chk("restart_count", 0, res_cnt[0] - n0, 1);
        chk("restart_cycle", 0, res_cyc[0], t + 11);
        chk("restart_value", 0, res_val[0], 24);
        t = 370;
        n0 = res_cnt[0];
        send(9, 9, t, 5);
        do_reset(t + 5);
        send(3, 4, t + 20, LEN);
        go(t + 50);
        chk("reset_count", 0, res_cnt[0] - n0, 1);
        chk("reset_cycle", 0, res_cyc[0], t + 28);
        chk("reset_value", 0, res_val[0], 7);
        t = 430;
        n0 = res_cnt[1];
        send(125, 125, t, LEN);
        do_reset(t + LEN + 3);
        send(1, 2, t + 20, LEN);
        go(t + 50);
        chk("midout_count", 1, res_cnt[1] - n0, 1);
        chk("midout_value", 1, res_val[1], 3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
